// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the control sequencer: opcodes, FSM states, ALU/shifter controls
// and the decoded-instruction payload.
package ctrl_seq_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'd1;
  localparam logic [OPC_W-1:0] OP_LDB = 4'd2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd3;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd4;
  localparam logic [OPC_W-1:0] OP_AND = 4'd5;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd6;
  localparam logic [OPC_W-1:0] OP_LSH = 4'd7;
  localparam logic [OPC_W-1:0] OP_RSH = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_EXEC, ST_SHIFT, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_HOLD = 2'b00, SH_RSH = 2'b01, SH_LSH = 2'b10
  } shift_state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_LOAD, CLS_ALU, CLS_SHIFT, CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    op_class_e cls;
    alu_op_e   alu_op;
    logic      sel_b;        // load targets B rather than A
    logic      shift_right;  // shift is RSH rather than LSH
  } dec_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction handshake and datapath control bundle between sequencer and datapath.
interface control_sequencer_if
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPW = 4,
  parameter int unsigned DW  = 4
);
  logic               instr_valid;
  logic [OPW+DW-1:0]  instr;
  logic               instr_ready;
  logic               shift_flag;
  logic               lda;
  logic               ldb;
  logic               ldo;
  logic [DW-1:0]      imm;
  alu_op_e            alu_op;
  logic               o_sel;
  logic               shift_load;
  shift_state_e       shift_state;
  logic               done;
  logic               busy;
  logic               underflow;
  logic               err;

  modport master (
    output instr_valid, instr, shift_flag,
    input  instr_ready, lda, ldb, ldo, imm, alu_op, o_sel, shift_load,
           shift_state, done, busy, underflow, err
  );

  modport slave (
    input  instr_valid, instr, shift_flag,
    output instr_ready, lda, ldb, ldo, imm, alu_op, o_sel, shift_load,
           shift_state, done, busy, underflow, err
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational opcode classifier: instruction class, ALU operation and load/shift selects.
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output dec_t           dec
);

  always_comb begin
    dec = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, sel_b: 1'b0, shift_right: 1'b0};
    case (opcode)
      OPW'(OP_NOP): dec.cls = CLS_NOP;
      OPW'(OP_LDA): dec.cls = CLS_LOAD;
      OPW'(OP_LDB): begin dec.cls = CLS_LOAD;  dec.sel_b = 1'b1;         end
      OPW'(OP_ADD): begin dec.cls = CLS_ALU;   dec.alu_op = ALU_ADD;     end
      OPW'(OP_SUB): begin dec.cls = CLS_ALU;   dec.alu_op = ALU_SUB;     end
      OPW'(OP_AND): begin dec.cls = CLS_ALU;   dec.alu_op = ALU_AND;     end
      OPW'(OP_OR):  begin dec.cls = CLS_ALU;   dec.alu_op = ALU_OR;      end
      OPW'(OP_LSH): dec.cls = CLS_SHIFT;
      OPW'(OP_RSH): begin dec.cls = CLS_SHIFT; dec.shift_right = 1'b1;   end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer driving register loads, ALU and shifter controls.
// Define SEQ_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they execute as NOP.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPW = 4,
  parameter int unsigned DW  = 4
) (
  input logic                clk,
  input logic                reset,
  control_sequencer_if.slave bus
);

  state_e        state_q;
  dec_t          dec_in;
  dec_t          dec_q;
  logic [DW-1:0] operand_q;
  logic [DW-1:0] count_q;
  logic          ready_q, busy_q, lda_q, ldb_q, ldo_q, o_sel_q, shift_load_q, done_q;
  logic          underflow_q;
  logic [DW-1:0] imm_q;
  alu_op_e       alu_op_q;
  shift_state_e  shift_state_q;
  shift_state_e  shift_dir;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .opcode (bus.instr[OPW+DW-1 -: OPW]),
    .dec    (dec_in)
  );

  assign shift_dir = dec_q.shift_right ? SH_RSH : SH_LSH;

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Outputs are registered on the transition into the cycle they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dec_q         <= '0;
      operand_q     <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      lda_q         <= 1'b0;
      ldb_q         <= 1'b0;
      ldo_q         <= 1'b0;
      o_sel_q       <= 1'b0;
      shift_load_q  <= 1'b0;
      done_q        <= 1'b0;
      underflow_q   <= 1'b0;
      imm_q         <= '0;
      alu_op_q      <= ALU_ADD;
      shift_state_q <= SH_HOLD;
`ifdef SEQ_ILLEGAL_TRAP_EN
      err_q         <= 1'b0;
`endif
    end else begin
      lda_q         <= 1'b0;
      ldb_q         <= 1'b0;
      ldo_q         <= 1'b0;
      o_sel_q       <= 1'b0;
      shift_load_q  <= 1'b0;
      done_q        <= 1'b0;
      shift_state_q <= SH_HOLD;
      case (state_q)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            dec_q       <= dec_in;
            operand_q   <= bus.instr[DW-1:0];
            count_q     <= bus.instr[DW-1:0];
            underflow_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_DECODE;
            // NOP completes in the DECODE cycle so ready cannot coincide with done.
`ifdef SEQ_ILLEGAL_TRAP_EN
            done_q      <= (dec_in.cls == CLS_NOP);
`else
            done_q      <= (dec_in.cls == CLS_NOP) || (dec_in.cls == CLS_ILLEGAL);
`endif
          end
        end
        ST_DECODE: begin
          case (dec_q.cls)
            CLS_LOAD: begin
              lda_q   <= ~dec_q.sel_b;
              ldb_q   <= dec_q.sel_b;
              imm_q   <= operand_q;
              done_q  <= 1'b1;
              state_q <= ST_EXEC;
            end
            CLS_ALU: begin
              alu_op_q <= dec_q.alu_op;
              state_q  <= ST_EXEC;
            end
            CLS_SHIFT: begin
              shift_load_q <= 1'b1;
              state_q      <= ST_EXEC;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            CLS_ILLEGAL: begin
              err_q   <= 1'b1;
              state_q <= ST_TRAP;
            end
`endif
            default: begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          endcase
        end
        ST_EXEC: begin
          if (dec_q.cls == CLS_ALU) begin
            ldo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_WB;
          end else if (dec_q.cls == CLS_SHIFT && count_q != '0) begin
            shift_state_q <= shift_dir;
            state_q       <= ST_SHIFT;
          end else if (dec_q.cls == CLS_SHIFT) begin
            ldo_q   <= 1'b1;
            o_sel_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_WB;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          count_q <= count_q - DW'(1);
          if (dec_q.shift_right && bus.shift_flag) underflow_q <= 1'b1;
          if (count_q == DW'(1)) begin
            ldo_q   <= 1'b1;
            o_sel_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_WB;
          end else begin
            shift_state_q <= shift_dir;
          end
        end
`ifdef SEQ_ILLEGAL_TRAP_EN
        ST_TRAP: state_q <= ST_TRAP;
`endif
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is masked by reset so the first cycle after release already shows it.
  assign bus.instr_ready = ready_q & ~reset;
  assign bus.busy        = busy_q;
  assign bus.lda         = lda_q;
  assign bus.ldb         = ldb_q;
  assign bus.ldo         = ldo_q;
  assign bus.imm         = imm_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.o_sel       = o_sel_q;
  assign bus.shift_load  = shift_load_q;
  assign bus.shift_state = shift_state_q;
  assign bus.done        = done_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed cycle-by-cycle expectations.
// Honours SEQ_ILLEGAL_TRAP_EN for the illegal-opcode scenario.
module tb_control_sequencer;
  import ctrl_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  control_sequencer_if #(.OPW(4), .DW(4)) bus ();

  control_sequencer #(.OPW(4), .DW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and consume the accept edge.
  task automatic offer(input logic [3:0] op, input logic [3:0] opnd);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, opnd};
    chk("offer_ready", 32'(bus.instr_ready), 32'd1);
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_lda"}, 32'(bus.lda), 32'd0);
    chk({tag, "_ldb"}, 32'(bus.ldb), 32'd0);
    chk({tag, "_ldo"}, 32'(bus.ldo), 32'd0);
    chk({tag, "_shl"}, 32'(bus.shift_load), 32'd0);
    chk({tag, "_sst"}, 32'(bus.shift_state), 32'd0);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.shift_flag  = 1'b0;

    // Reset
    step(); step();
    chk("rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_uf", 32'(bus.underflow), 32'd0);
    chk_quiet("rst");
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.instr_ready), 32'd1);

    // LDA 5: strobe two cycles after accept
    offer(OP_LDA, 4'd5);
    chk("lda_dec_ready", 32'(bus.instr_ready), 32'd0);
    chk("lda_dec_busy", 32'(bus.busy), 32'd1);
    chk("lda_dec_done", 32'(bus.done), 32'd0);
    chk_quiet("lda_dec");
    step();
    chk("lda_strobe", 32'(bus.lda), 32'd1);
    chk("lda_ldb", 32'(bus.ldb), 32'd0);
    chk("lda_ldo", 32'(bus.ldo), 32'd0);
    chk("lda_imm", 32'(bus.imm), 32'd5);
    chk("lda_done", 32'(bus.done), 32'd1);
    chk("lda_ready_during_done", 32'(bus.instr_ready), 32'd0);
    step();
    chk("lda_after_ready", 32'(bus.instr_ready), 32'd1);
    chk("lda_after_busy", 32'(bus.busy), 32'd0);
    chk("lda_after_done", 32'(bus.done), 32'd0);
    chk_quiet("lda_after");

    // LDB 9
    offer(OP_LDB, 4'd9);
    step();
    chk("ldb_strobe", 32'(bus.ldb), 32'd1);
    chk("ldb_lda", 32'(bus.lda), 32'd0);
    chk("ldb_imm", 32'(bus.imm), 32'd9);
    chk("ldb_done", 32'(bus.done), 32'd1);
    step();

    // ADD with SUB held on the bus during execution (must wait unconsumed)
    offer(OP_ADD, 4'd0);
    bus.instr_valid = 1'b1;
    bus.instr       = {OP_SUB, 4'd0};
    chk("add_dec_ready", 32'(bus.instr_ready), 32'd0);
    step();
    chk("add_exec_ldo", 32'(bus.ldo), 32'd0);
    chk("add_exec_done", 32'(bus.done), 32'd0);
    chk("add_exec_aluop", 32'(bus.alu_op), 32'(ALU_ADD));
    step();
    chk("add_wb_ldo", 32'(bus.ldo), 32'd1);
    chk("add_wb_osel", 32'(bus.o_sel), 32'd0);
    chk("add_wb_aluop", 32'(bus.alu_op), 32'(ALU_ADD));
    chk("add_wb_done", 32'(bus.done), 32'd1);
    chk("add_wb_ready", 32'(bus.instr_ready), 32'd0);
    step();
    chk("add_idle_done", 32'(bus.done), 32'd0);
    chk("sub_wait_ready", 32'(bus.instr_ready), 32'd1);
    step();
    bus.instr_valid = 1'b0;
    chk("sub_dec_busy", 32'(bus.busy), 32'd1);
    step(); step();
    chk("sub_wb_ldo", 32'(bus.ldo), 32'd1);
    chk("sub_wb_aluop", 32'(bus.alu_op), 32'(ALU_SUB));
    chk("sub_wb_done", 32'(bus.done), 32'd1);
    step();

    // LSH 3: one load cycle, three shift cycles, then write-back from shifter
    offer(OP_LSH, 4'd3);
    chk("lsh_dec_shl", 32'(bus.shift_load), 32'd0);
    step();
    chk("lsh_exec_shl", 32'(bus.shift_load), 32'd1);
    chk("lsh_exec_sst", 32'(bus.shift_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lsh_shift_sst", 32'(bus.shift_state), 32'(SH_LSH));
      chk("lsh_shift_shl", 32'(bus.shift_load), 32'd0);
      chk("lsh_shift_ldo", 32'(bus.ldo), 32'd0);
    end
    step();
    chk("lsh_wb_ldo", 32'(bus.ldo), 32'd1);
    chk("lsh_wb_osel", 32'(bus.o_sel), 32'd1);
    chk("lsh_wb_sst", 32'(bus.shift_state), 32'd0);
    chk("lsh_wb_done", 32'(bus.done), 32'd1);
    step();
    chk("lsh_idle_ready", 32'(bus.instr_ready), 32'd1);

    // LSH 0: no shift cycles
    offer(OP_LSH, 4'd0);
    step();
    chk("lsh0_exec_shl", 32'(bus.shift_load), 32'd1);
    step();
    chk("lsh0_wb_ldo", 32'(bus.ldo), 32'd1);
    chk("lsh0_wb_osel", 32'(bus.o_sel), 32'd1);
    chk("lsh0_wb_sst", 32'(bus.shift_state), 32'd0);
    chk("lsh0_wb_done", 32'(bus.done), 32'd1);
    step();

    // RSH 2 with shift_flag high in the second shift cycle
    offer(OP_RSH, 4'd2);
    step();
    chk("rsh_exec_shl", 32'(bus.shift_load), 32'd1);
    step();
    chk("rsh_s1_sst", 32'(bus.shift_state), 32'(SH_RSH));
    chk("rsh_s1_uf", 32'(bus.underflow), 32'd0);
    step();
    bus.shift_flag = 1'b1;
    chk("rsh_s2_sst", 32'(bus.shift_state), 32'(SH_RSH));
    chk("rsh_s2_uf", 32'(bus.underflow), 32'd0);
    step();
    bus.shift_flag = 1'b0;
    chk("rsh_wb_uf", 32'(bus.underflow), 32'd1);
    chk("rsh_wb_ldo", 32'(bus.ldo), 32'd1);
    chk("rsh_wb_osel", 32'(bus.o_sel), 32'd1);
    step();
    chk("rsh_idle_uf", 32'(bus.underflow), 32'd1);
    offer(OP_NOP, 4'd0);
    chk("nop_uf_cleared", 32'(bus.underflow), 32'd0);
    chk("nop_done", 32'(bus.done), 32'd1);
    chk_quiet("nop");
    step();
    chk("nop_idle_done", 32'(bus.done), 32'd0);
    chk("nop_idle_ready", 32'(bus.instr_ready), 32'd1);

    // RSH 4 abandoned by reset during SHIFT
    offer(OP_RSH, 4'd4);
    step(); step(); step();
    chk("rsh4_shift_sst", 32'(bus.shift_state), 32'(SH_RSH));
    reset = 1'b1;
    step();
    chk("rsh4_rst_ldo", 32'(bus.ldo), 32'd0);
    chk("rsh4_rst_done", 32'(bus.done), 32'd0);
    chk("rsh4_rst_busy", 32'(bus.busy), 32'd0);
    chk("rsh4_rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("rsh4_rst_sst", 32'(bus.shift_state), 32'd0);
    reset = 1'b0;
    #1;
    chk("rsh4_rel_ready", 32'(bus.instr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rsh4_post_done", 32'(bus.done), 32'd0);
      chk("rsh4_post_ldo", 32'(bus.ldo), 32'd0);
      chk("rsh4_post_ready", 32'(bus.instr_ready), 32'd1);
    end

    // Illegal opcode 12
    offer(4'd12, 4'd3);
`ifdef SEQ_ILLEGAL_TRAP_EN
    chk("ill_dec_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ill_trap_err", 32'(bus.err), 32'd1);
      chk("ill_trap_ready", 32'(bus.instr_ready), 32'd0);
      chk("ill_trap_busy", 32'(bus.busy), 32'd1);
      chk("ill_trap_done", 32'(bus.done), 32'd0);
      chk_quiet("ill_trap");
    end
    reset = 1'b1;
    step();
    chk("ill_rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    #1;
    chk("ill_rel_ready", 32'(bus.instr_ready), 32'd1);
`else
    chk("ill_dec_done", 32'(bus.done), 32'd1);
    chk("ill_dec_err", 32'(bus.err), 32'd0);
    chk_quiet("ill_dec");
    step();
    chk("ill_idle_done", 32'(bus.done), 32'd0);
    chk("ill_idle_ready", 32'(bus.instr_ready), 32'd1);
    chk("ill_idle_err", 32'(bus.err), 32'd0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 4, opcode width; parameter DW, default 4, datapath/operand width.
REQ-002 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have instr_valid  input  1  instruction offered; instr  input  OPW+DW  {opcode, operand}.
REQ-005 SHALL have instr_ready  output  1  sequencer can accept an instruction.
REQ-006 SHALL have shift_flag  input  1  underflow flag from the shift register.
REQ-007 SHALL have lda, ldb, ldo  output  1 each  register load strobes; imm  output  DW  immediate for A/B loads.
REQ-008 SHALL have alu_op  output  2  (00 ADD, 01 SUB, 10 AND, 11 OR); o_sel  output  1  (0 ALU, 1 shifter) into O.
REQ-009 SHALL have shift_load  output  1; shift_state  output  2  (10 LSH, 01 RSH, 00 hold).
REQ-010 SHALL have done  output  1  one-cycle completion pulse; busy  output  1; underflow  output  1; err  output  1 (REQ-032).

Function
REQ-011 SHALL implement states IDLE, DECODE, EXEC, SHIFT, WB (and TRAP under REQ-032).
REQ-012 SHALL assert instr_ready only in IDLE; busy = not IDLE.
REQ-013 SHALL accept on instr_valid & instr_ready, latching instr and count = operand, clearing underflow, moving to DECODE.
REQ-014 SHALL ignore instr_valid outside IDLE; an offered instruction waits, unconsumed.
REQ-015 SHALL decode opcodes: 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 LSH, 8 RSH; 9-15 illegal.
REQ-016 DECODE SHALL go to EXEC for legal opcodes except NOP; NOP and illegal (macro off) SHALL pulse done and return to IDLE.
REQ-017 EXEC LDA/LDB SHALL assert lda/ldb for exactly one cycle with imm = operand, pulse done, return to IDLE (accept-to-strobe latency 2 cycles).
REQ-018 EXEC ALU ops SHALL drive alu_op, go to WB; WB SHALL assert ldo with o_sel=0, alu_op held, pulse done.
REQ-019 EXEC LSH/RSH SHALL assert shift_load one cycle, go to SHIFT if count != 0, else straight to WB.
REQ-020 SHIFT SHALL drive shift_state (10 LSH / 01 RSH) each cycle, decrement count, go to WB after the cycle where count reaches 0: exactly operand shift cycles.
REQ-021 WB for shifts SHALL assert ldo with o_sel=1 and shift_state=00.
REQ-022 During RSH SHIFT cycles, shift_flag high SHALL set underflow; underflow SHALL stay set until next accept or reset.
REQ-023 Outside their defined cycles lda, ldb, ldo, shift_load, done SHALL be 0 and shift_state 00.
REQ-024 At most one of lda, ldb, ldo SHALL be high in any cycle.
REQ-025 Back-to-back instructions SHALL be accepted no earlier than the cycle after done.

Reset
REQ-026 While reset is high, all outputs SHALL be 0 and state forced to IDLE on the next edge.
REQ-027 Reset mid-instruction SHALL abandon it with no further strobes and no done pulse.
REQ-028 First cycle after reset deasserts SHALL show instr_ready=1.
REQ-029 Reset SHALL clear count, latched instr, underflow, err.

Configuration
REQ-030 Macro SEQ_ILLEGAL_TRAP_EN SHALL select illegal-opcode handling.
REQ-031 Without it, illegal opcodes SHALL behave as NOP and err SHALL be tied 0.
REQ-032 With it, illegal opcodes SHALL enter TRAP: err=1, instr_ready=0, busy=1, no done, held until reset.

Structure
REQ-033 Package ctrl_seq_pkg SHALL hold opcode constants, state encoding, alu_op and shift_state encodings.
REQ-034 Combinational sub-module ctrl_decode SHALL map opcode to class (load, alu, shift, nop, illegal) and alu_op.

Verification
REQ-035 Reset, then LDA operand 5 -> lda=1 with imm=5 two cycles after accept, done same cycle, ready next.
REQ-036 ADD -> WB cycle: ldo=1, o_sel=0, alu_op=00, done=1; SUB gives alu_op=01.
REQ-037 LSH 3 -> shift_load 1 cycle, shift_state=10 for exactly 3 cycles, then ldo with o_sel=1; LSH 0 -> shift_load then ldo, no shift cycles.
REQ-038 RSH 2 with shift_flag high in second shift cycle -> underflow=1 held to next accept, then cleared.
REQ-039 Reset asserted during SHIFT of RSH 4 -> no ldo, no done; ready=1 the cycle after reset deasserts.
REQ-040 Opcode 12: macro off -> done pulse, no strobes; macro on -> err=1, ready=0 until reset.
